// File: rtl/lpc_record_fifo.sv
// ---------------------------------------------------------------------------
// lpc_record_fifo
//
// Record FIFO sitting between the LPC cycle decoder and the UART byte path.
// Each decoded LPC cycle is stored as one fixed-size record:
//     {4'h0, cyctype_dir}, address MSB..LSB, data
// The stored records are then serialised MSB-first onto an 8-bit
// valid/ready byte stream. The write side never stalls the sniffer. When the
// FIFO is full, the incoming record is dropped, the sticky overflow flag is
// set and the drop counter is incremented. The counter saturates.
//
// Optional feature (compile-time macro LPC_RECORD_FIFO_MARKER_EN):
//   When the macro is defined, drops accumulate in drop_count. In the first
//   cycle where the FIFO is not full and drop_count is non-zero, a marker
//   record {8'hFF, drop_count (zero-extended), 8'hFF} is written and the
//   counter is cleared. The marker takes priority over a strobe in the same
//   cycle. That strobe is dropped and becomes the new count of 1.
//   When the macro is undefined, drop_count is the total number of drops
//   since reset.
//
// Parameters
//   ADDR_W      captured address width, multiple of 8, 8..32
//   DEPTH_LOG2  record slots = 2**DEPTH_LOG2
//   DROP_W      drop counter width (<= ADDR_W), saturating
//
// Ports
//   clock           single clock
//   reset           asynchronous, active-low
//   in_valid        one-cycle strobe qualifying in_cyctype_dir/in_addr/in_data
//   in_cyctype_dir  LPC cycle type / direction
//   in_addr         LPC address
//   in_data         LPC data byte
//   out_valid       out_data holds a valid byte
//   out_ready       sink accepts the byte when out_valid && out_ready
//   out_data        serialised byte
//   level           number of stored records, 0..2**DEPTH_LOG2
//   empty           level == 0
//   overflow        sticky, set on the first drop
//   drop_count      dropped-record counter
// ---------------------------------------------------------------------------
module lpc_record_fifo #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int DROP_W     = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [3:0]            in_cyctype_dir,
    input  logic [ADDR_W-1:0]     in_addr,
    input  logic [7:0]            in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count
);

    localparam int REC_BYTES = 2 + ADDR_W / 8;
    localparam int REC_W     = 8 * REC_BYTES;
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int PTR_W     = DEPTH_LOG2 + 1;
    localparam int IDX_W     = $clog2(REC_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REC_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Record storage. Contents need no reset because the pointers qualify them.
    logic [REC_W-1:0]  mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    state_t            state_q, state_d;
    logic [REC_W-1:0]  shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              full_w;
    logic              empty_w;
    logic [PTR_W-1:0]  level_w;
    logic              wr_en;
    logic [REC_W-1:0]  wr_rec;

    // Status comes from the registered pointers. This means a slot freed by
    // a pop in this cycle cannot take a write until the next cycle.
    always_comb begin
        full_w  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        empty_w = (wr_ptr_q == rd_ptr_q);
        level_w = wr_ptr_q - rd_ptr_q;
    end

    // Write side: store, drop, or (optionally) insert a marker record.
    always_comb begin
        wr_en      = 1'b0;
        wr_rec     = {4'h0, in_cyctype_dir, in_addr, in_data};
        overflow_d = overflow_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
`ifdef LPC_RECORD_FIFO_MARKER_EN
        if (!full_w && (drop_q != '0)) begin
            // The marker wins the free slot. A coincident strobe is lost
            // and starts the next drop count.
            wr_en  = 1'b1;
            wr_rec = {8'hFF, ADDR_W'(drop_q), 8'hFF};
            if (in_valid) begin
                drop_d     = DROP_W'(1);
                overflow_d = 1'b1;
            end else begin
                drop_d = '0;
            end
        end else if (in_valid) begin
            if (full_w) begin
                overflow_d = 1'b1;
                drop_d     = sat_inc(drop_q);
            end else begin
                wr_en = 1'b1;
            end
        end
`else
        if (in_valid) begin
            if (full_w) begin
                overflow_d = 1'b1;
                drop_d     = sat_inc(drop_q);
            end else begin
                wr_en = 1'b1;
            end
        end
`endif
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_rec;
        end
    end

    // Serialiser. LOAD copies the head record into the shift register. SEND
    // presents its top byte and shifts on each accepted byte.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        rd_ptr_d  = rd_ptr_q;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == IDX_LAST) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        idx_d    = '0;
                        // level still counts the record being retired.
                        state_d  = (level_w > PTR_W'(1)) ? S_LOAD : S_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q << 8;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= S_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        out_data   = shift_q[REC_W-1 -: 8];
        level      = level_w;
        empty      = empty_w;
        overflow   = overflow_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_lpc_record_fifo.sv
// ---------------------------------------------------------------------------
// tb_lpc_record_fifo
//
// Directed bench for lpc_record_fifo. The main instance uses the default
// parameters. A second, small instance (ADDR_W=8, 4 slots, DROP_W=4) is
// used for drop-counter saturation.
// ---------------------------------------------------------------------------
module tb_lpc_record_fifo;

    logic        clock;
    logic        reset;

    logic        in_valid;
    logic [3:0]  in_cyctype_dir;
    logic [31:0] in_addr;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [5:0]  level;
    logic        empty;
    logic        overflow;
    logic [15:0] drop_count;

    logic        s_in_valid;
    logic [3:0]  s_cyctype_dir;
    logic [7:0]  s_addr;
    logic [7:0]  s_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [7:0]  s_out_data;
    logic [2:0]  s_level;
    logic        s_empty;
    logic        s_overflow;
    logic [3:0]  s_drop_count;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  rx [0:255];
    int          rx_n;

    lpc_record_fifo u_dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_cyctype_dir (in_cyctype_dir),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .level          (level),
        .empty          (empty),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    lpc_record_fifo #(.ADDR_W(8), .DEPTH_LOG2(2), .DROP_W(4)) u_sat (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (s_in_valid),
        .in_cyctype_dir (s_cyctype_dir),
        .in_addr        (s_addr),
        .in_data        (s_data),
        .out_valid      (s_out_valid),
        .out_ready      (s_out_ready),
        .out_data       (s_out_data),
        .level          (s_level),
        .empty          (s_empty),
        .overflow       (s_overflow),
        .drop_count     (s_drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        in_valid       = 1'b0;
        in_cyctype_dir = '0;
        in_addr        = '0;
        in_data        = '0;
        out_ready      = 1'b0;
        s_in_valid     = 1'b0;
        s_cyctype_dir  = '0;
        s_addr         = '0;
        s_data         = '0;
        s_out_ready    = 1'b0;
        reset          = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // One-cycle strobe; returns at #1 after the edge that captured it.
    task automatic send(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d);
        in_valid       = 1'b1;
        in_cyctype_dir = ct;
        in_addr        = a;
        in_data        = d;
        tick();
        in_valid = 1'b0;
    endtask

    // Accepts n bytes into rx[]. With toggle set, out_ready alternates
    // 1,0,1,0... While a byte is stalled, it must stay valid and unchanged.
    task automatic drain(input int n, input bit toggle, input int budget);
        int         got;
        int         cyc;
        bit         stalled;
        logic [7:0] held;
        got     = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (got < n && cyc < budget) begin
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(held));
            end
            out_ready = toggle ? ~cyc[0] : 1'b1;
            if (out_valid && out_ready) begin
                rx[rx_n] = out_data;
                rx_n++;
                got++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held    = out_data;
            end
            tick();
            cyc++;
        end
        if (got < n) check("drain_timeout", 64'(got), 64'(n));
    endtask

    task automatic check_rec(input string tag, input int base, input logic [47:0] exp);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s_b%0d", tag, k), 64'(rx[base+k]), 64'(exp[47-8*k -: 8]));
        end
    endtask

    initial begin
        int idle_seen;
        reset = 1'b0;
        apply_reset();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);

        // Single record: latency and byte order
        out_ready = 1'b1;
        rx_n = 0;
        send(4'h2, 32'h0000_0080, 8'h5A);
        check("t1_empty_n1", 64'(empty), 64'd0);
        check("t1_level_n1", 64'(level), 64'd1);
        check("t1_valid_n1", 64'(out_valid), 64'd0);
        tick();
        check("t1_valid_n2", 64'(out_valid), 64'd0);
        tick();
        check("t1_valid_n3", 64'(out_valid), 64'd1);
        check("t1_data_n3", 64'(out_data), 64'h02);
        drain(6, 1'b0, 50);
        check_rec("t1", 0, 48'h02_00_00_00_80_5A);
        check("t1_empty_after", 64'(empty), 64'd1);
        check("t1_level_after", 64'(level), 64'd0);
        check("t1_valid_after", 64'(out_valid), 64'd0);

        // Back-pressure with a 1010 ready pattern
        rx_n = 0;
        send(4'h3, 32'h1234_5678, 8'hA5);
        drain(6, 1'b1, 60);
        check_rec("t2", 0, 48'h03_12_34_56_78_A5);
        out_ready = 1'b0;
        tick();
        check("t2_empty_after", 64'(empty), 64'd1);

        // Fill: 33 strobes into 32 slots while the sink is stalled
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 33; i++) begin
            send(4'(i), 32'h1000_0000 + 32'(i), 8'h40 + 8'(i));
        end
        check("t3_level", 64'(level), 64'd32);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_drop", 64'(drop_count), 64'd1);
        rx_n = 0;
        drain(192, 1'b0, 600);
        check_rec("t3_first", 0, 48'h00_10_00_00_00_40);
        check_rec("t3_last", 186, 48'h0F_10_00_00_1F_5F);
        idle_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (!out_valid) idle_seen++;
            tick();
        end
        check("t3_no_33rd", 64'(idle_seen), 64'd8);
        check("t3_level_end", 64'(level), 64'd0);
        check("t3_overflow_end", 64'(overflow), 64'd1);

        // Saturation on the DROP_W=4 instance
        apply_reset();
        for (int i = 0; i < 18; i++) begin
            s_in_valid    = 1'b1;
            s_cyctype_dir = 4'(i);
            s_addr        = 8'(i);
            s_data        = 8'(i);
            tick();
        end
        s_in_valid = 1'b0;
        check("t4_level", 64'(s_level), 64'd4);
        check("t4_drop14", 64'(s_drop_count), 64'hE);
        check("t4_overflow", 64'(s_overflow), 64'd1);
        s_in_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        s_in_valid = 1'b0;
        check("t4_drop_sat", 64'(s_drop_count), 64'hF);

        // Fill, drop 3, drain one record
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 35; i++) begin
            send(4'(i), 32'h1000_0000 + 32'(i), 8'h40 + 8'(i));
        end
        check("t5_drop3", 64'(drop_count), 64'd3);
        rx_n = 0;
        drain(6, 1'b0, 40);
        out_ready = 1'b0;
        check_rec("t5_rec0", 0, 48'h00_10_00_00_00_40);
        tick();
`ifdef LPC_RECORD_FIFO_MARKER_EN
        check("t5_drop_cleared", 64'(drop_count), 64'd0);
        check("t5_level", 64'(level), 64'd32);
        check("t5_overflow", 64'(overflow), 64'd1);
        rx_n = 0;
        drain(192, 1'b0, 600);
        check_rec("t5_marker", 186, 48'hFF_00_00_00_03_FF);
`else
        check("t5_drop_kept", 64'(drop_count), 64'd3);
        check("t5_level", 64'(level), 64'd31);
        check("t5_overflow", 64'(overflow), 64'd1);
        rx_n = 0;
        drain(186, 1'b0, 600);
        check_rec("t5_last", 180, 48'h0F_10_00_00_1F_5F);
`endif

        // Reset in the middle of a record
        apply_reset();
        out_ready = 1'b1;
        rx_n = 0;
        send(4'h2, 32'h0000_0080, 8'h5A);
        drain(3, 1'b0, 30);
        reset = 1'b0;
        #1;
        check("t6_valid_rst", 64'(out_valid), 64'd0);
        check("t6_level_rst", 64'(level), 64'd0);
        check("t6_empty_rst", 64'(empty), 64'd1);
        tick();
        reset = 1'b1;
        idle_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (!out_valid) idle_seen++;
            tick();
        end
        check("t6_quiet", 64'(idle_seen), 64'd6);
        rx_n = 0;
        send(4'h1, 32'hDEAD_BEEF, 8'h77);
        drain(6, 1'b0, 50);
        check_rec("t6", 0, 48'h01_DE_AD_BE_EF_77);
        check("t6_empty_after", 64'(empty), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
